// File: rtl/tiny_processor_core_if.sv
// Bundle of program-load, control and observation signals of the tiny
// accumulator core. The host drives through 'master', the core sits on 'slave'.
interface tiny_processor_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic                prog_we;
  logic [ADDR_W-1:0]   prog_addr;
  logic [ADDR_W+3:0]   prog_data;
  logic                start;
  logic                stop;
  logic                step;
  logic [1:0]          state_out;
  logic [ADDR_W-1:0]   pc_out;
  logic [DATA_W-1:0]   acc_out;
  logic [ADDR_W-1:0]   dbg_addr;
  logic [DATA_W-1:0]   dbg_data;
  logic                st_valid;
  logic [ADDR_W-1:0]   st_addr;
  logic [DATA_W-1:0]   st_data;

  modport master (
    output prog_we, prog_addr, prog_data, start, stop, step, dbg_addr,
    input  state_out, pc_out, acc_out, dbg_data, st_valid, st_addr, st_data
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, stop, step, dbg_addr,
    output state_out, pc_out, acc_out, dbg_data, st_valid, st_addr, st_data
  );

endinterface

// File: rtl/tiny_processor_core.sv
// Single-cycle accumulator processor with host-loadable instruction memory,
// a run/pause/step/halt controller, a combinational debug read port on the
// data memory and a registered store-observation strobe.
// Instruction word is {operand[ADDR_W-1:0], opcode[3:0]}. DATA_W must be
// at least ADDR_W so immediates can be sign-extended into the accumulator.
module tiny_processor_core #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter bit WRAP_EN = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  tiny_processor_core_if.slave bus
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int INSTR_W = ADDR_W + 4;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_NOP  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BNEZ = 4'hD;
  localparam logic [3:0] OP_BEQZ = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [INSTR_W-1:0] HALT_WORD = {{ADDR_W{1'b0}}, OP_HALT};
  localparam logic [ADDR_W-1:0]  PC_LAST   = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [INSTR_W-1:0]  r_imem [DEPTH];
  logic [DATA_W-1:0]   r_dmem [DEPTH];
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_acc;
  logic                r_stValid;
  logic [ADDR_W-1:0]   r_stAddr;
  logic [DATA_W-1:0]   r_stData;

  logic [INSTR_W-1:0]  w_instr;
  logic [3:0]          w_opcode;
  logic [ADDR_W-1:0]   w_operand;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_memOperand;
  logic                w_shiftTooFar;
  logic [DATA_W-1:0]   w_nextAcc;
  logic [ADDR_W-1:0]   w_nextPc;
  logic                w_jumpTaken;
  logic                w_isHalt;
  logic                w_isStore;
  logic                w_execHalts;
  logic                w_exec;
  logic                w_restart;
  logic                w_imemWrite;

  // Fetch and field extraction for the instruction at the current pc.
  assign w_instr       = r_imem[r_pc];
  assign w_opcode      = w_instr[3:0];
  assign w_operand     = w_instr[INSTR_W-1:4];
  assign w_imm         = DATA_W'($signed(w_operand));
  assign w_memOperand  = r_dmem[w_operand];
  assign w_shiftTooFar = (int'(w_operand) >= DATA_W);

  // Control decode: stop outranks start, start outranks step; stop only
  // matters in RUN and step only in PAUSE. Host writes are locked out in RUN.
  assign w_exec      = ((r_state == RUN) && !bus.stop) ||
                       ((r_state == PAUSE) && !bus.start && bus.step);
  assign w_restart   = ((r_state == IDLE) || (r_state == HALT)) && bus.start;
  assign w_imemWrite = bus.prog_we && (r_state != RUN);

  // Execute datapath: the accumulator result and control-flow effect of
  // the current instruction, applied only on cycles where w_exec is set.
  always_comb begin
    w_nextAcc   = r_acc;
    w_jumpTaken = 1'b0;
    w_isHalt    = 1'b0;
    w_isStore   = 1'b0;
    case (w_opcode)
      OP_ADD:  w_nextAcc = r_acc + w_memOperand;
      OP_SUB:  w_nextAcc = r_acc - w_memOperand;
      OP_AND:  w_nextAcc = r_acc & w_memOperand;
      OP_OR:   w_nextAcc = r_acc | w_memOperand;
      OP_XOR:  w_nextAcc = r_acc ^ w_memOperand;
      OP_SHL:  w_nextAcc = w_shiftTooFar ? '0 : (r_acc << w_operand);
      OP_SHR:  w_nextAcc = w_shiftTooFar ? '0 : (r_acc >> w_operand);
      OP_NOP:  w_nextAcc = r_acc;
      OP_ADDI: w_nextAcc = r_acc + w_imm;
      OP_LDI:  w_nextAcc = w_imm;
      OP_LD:   w_nextAcc = w_memOperand;
      OP_ST:   w_isStore = 1'b1;
      OP_JMP:  w_jumpTaken = 1'b1;
      OP_BNEZ: w_jumpTaken = (r_acc != '0);
      OP_BEQZ: w_jumpTaken = (r_acc == '0);
      OP_HALT: w_isHalt = 1'b1;
      default: w_nextAcc = r_acc;
    endcase
  end

  // Next pc and halt detection; falling off the last address halts in
  // place unless wrap-around is enabled.
  always_comb begin
    w_nextPc    = r_pc + 1'b1;
    w_execHalts = 1'b0;
    if (w_isHalt) begin
      w_nextPc    = r_pc;
      w_execHalts = 1'b1;
    end else if (w_jumpTaken) begin
      w_nextPc = w_operand;
    end else if ((r_pc == PC_LAST) && !WRAP_EN) begin
      w_nextPc    = r_pc;
      w_execHalts = 1'b1;
    end
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Controller next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, HALT: begin
        if (bus.start) w_nextState = RUN;
      end
      RUN: begin
        if (bus.stop)         w_nextState = PAUSE;
        else if (w_execHalts) w_nextState = HALT;
      end
      PAUSE: begin
        if (bus.start)                     w_nextState = RUN;
        else if (bus.step && w_execHalts)  w_nextState = HALT;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Controller outputs and observation ports, all driven from registers
  // except the combinational debug read.
  always_comb begin
    bus.state_out = r_state;
    bus.pc_out    = r_pc;
    bus.acc_out   = r_acc;
    bus.dbg_data  = r_dmem[bus.dbg_addr];
    bus.st_valid  = r_stValid;
    bus.st_addr   = r_stAddr;
    bus.st_data   = r_stData;
  end

  // Program counter and accumulator: cleared on restart, retired on execute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= '0;
      r_acc <= '0;
    end else if (w_restart) begin
      r_pc  <= '0;
      r_acc <= '0;
    end else if (w_exec) begin
      r_pc  <= w_nextPc;
      r_acc <= w_nextAcc;
    end
  end

  // Data memory: cleared by reset, written by an executed ST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_dmem[i] <= '0;
    end else if (w_exec && w_isStore) begin
      r_dmem[w_operand] <= r_acc;
    end
  end

  // Instruction memory: reset fills it with HALT, host loads it while stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_imem[i] <= HALT_WORD;
    end else if (w_imemWrite) begin
      r_imem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Store strobe: one-cycle pulse after each executed ST, address/data held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stValid <= 1'b0;
      r_stAddr  <= '0;
      r_stData  <= '0;
    end else begin
      r_stValid <= w_exec && w_isStore;
      if (w_exec && w_isStore) begin
        r_stAddr <= w_operand;
        r_stData <= r_acc;
      end
    end
  end

endmodule

// File: tb/tb_tiny_processor_core.sv
// Directed testbench for tiny_processor_core: a stepped instruction table
// plus hand-written sequences for run/pause/step, halting, wrap and reset.
module tb_tiny_processor_core;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] instr;
    logic [7:0] acc;
    logic [3:0] pc;
    logic       stValid;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[16];

  tiny_processor_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) busA ();
  tiny_processor_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) busW ();

  tiny_processor_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRAP_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(busA)
  );

  tiny_processor_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRAP_EN(1'b1)) dutWrap (
    .clk(clk), .rst(rst), .bus(busW)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic st);
    busA.start = s;
    busA.stop  = p;
    busA.step  = st;
    tick();
    busA.start = 1'b0;
    busA.stop  = 1'b0;
    busA.step  = 1'b0;
  endtask

  task automatic loadWord(input logic [3:0] addr, input logic [7:0] data);
    busA.prog_we   = 1'b1;
    busA.prog_addr = addr;
    busA.prog_data = data;
    tick();
    busA.prog_we = 1'b0;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic waitHalt(input int budget, input string name);
    for (int i = 0; i < budget && busA.state_out != 2'b11; i++) tick();
    checkOutput(name, busA.state_out, 2'b11);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] loopAcc[7];
    logic [3:0] stepPc[3];
    logic [7:0] stepAcc[3];

    vecs[0]  = '{4'd0,  8'h19, 8'h01, 4'd1,  1'b0};
    vecs[1]  = '{4'd1,  8'h0B, 8'h01, 4'd2,  1'b1};
    vecs[2]  = '{4'd2,  8'h09, 8'h00, 4'd3,  1'b0};
    vecs[3]  = '{4'd3,  8'h01, 8'hFF, 4'd4,  1'b0};
    vecs[4]  = '{4'd4,  8'h95, 8'h00, 4'd5,  1'b0};
    vecs[5]  = '{4'd5,  8'hF9, 8'hFF, 4'd6,  1'b0};
    vecs[6]  = '{4'd6,  8'h45, 8'hF0, 4'd7,  1'b0};
    vecs[7]  = '{4'd7,  8'h46, 8'h0F, 4'd8,  1'b0};
    vecs[8]  = '{4'd8,  8'h02, 8'h01, 4'd9,  1'b0};
    vecs[9]  = '{4'd9,  8'h04, 8'h00, 4'd10, 1'b0};
    vecs[10] = '{4'd10, 8'hDE, 8'h00, 4'd13, 1'b0};
    vecs[11] = '{4'd13, 8'h68, 8'h06, 4'd14, 1'b0};
    vecs[12] = '{4'd14, 8'h03, 8'h07, 4'd15, 1'b0};
    vecs[13] = '{4'd15, 8'hBC, 8'h07, 4'd11, 1'b0};
    vecs[14] = '{4'd11, 8'h00, 8'h08, 4'd12, 1'b0};
    vecs[15] = '{4'd12, 8'h0A, 8'h01, 4'd13, 1'b0};

    loopAcc = '{8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0};
    stepPc  = '{4'd1, 4'd2, 4'd1};
    stepAcc = '{8'd2, 8'd1, 8'd1};

    busA.prog_we = 1'b0; busA.prog_addr = '0; busA.prog_data = '0;
    busA.start = 1'b0; busA.stop = 1'b0; busA.step = 1'b0; busA.dbg_addr = '0;
    busW.prog_we = 1'b0; busW.prog_addr = '0; busW.prog_data = '0;
    busW.start = 1'b0; busW.stop = 1'b0; busW.step = 1'b0; busW.dbg_addr = '0;

    #12 rst = 1'b0;
    tick();
    checkOutput("reset state", busA.state_out, 2'b00);
    checkOutput("reset pc", busA.pc_out, 0);
    checkOutput("reset acc", busA.acc_out, 0);
    checkOutput("reset st_valid", busA.st_valid, 0);

    // LDI 5, ST 2, HALT
    loadWord(4'd0, 8'h59);
    loadWord(4'd1, 8'h2B);
    loadWord(4'd2, 8'h0F);
    busA.dbg_addr = 4'd2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start to run", busA.state_out, 2'b01);
    checkOutput("start pc", busA.pc_out, 0);
    tick();
    checkOutput("ldi acc", busA.acc_out, 8'h05);
    tick();
    checkOutput("st valid", busA.st_valid, 1);
    checkOutput("st addr", busA.st_addr, 2);
    checkOutput("st data", busA.st_data, 8'h05);
    checkOutput("dbg after st", busA.dbg_data, 8'h05);
    tick();
    checkOutput("halt state", busA.state_out, 2'b11);
    checkOutput("halt pc", busA.pc_out, 2);
    checkOutput("st pulse ends", busA.st_valid, 0);

    // Countdown loop: LDI 3, ADDI -1, BNEZ 1, HALT
    loadWord(4'd0, 8'h39);
    loadWord(4'd1, 8'hF8);
    loadWord(4'd2, 8'h1D);
    loadWord(4'd3, 8'h0F);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart acc", busA.acc_out, 0);
    checkOutput("dmem kept on restart", busA.dbg_data, 8'h05);
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput($sformatf("loop acc %0d", i), busA.acc_out, loopAcc[i]);
    end
    checkOutput("loop still running", busA.state_out, 2'b01);
    tick();
    checkOutput("loop halt state", busA.state_out, 2'b11);
    checkOutput("loop halt pc", busA.pc_out, 3);
    checkOutput("loop halt acc", busA.acc_out, 0);

    // Same loop with pause, single steps and resume
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pause state", busA.state_out, 2'b10);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("pause pc frozen", busA.pc_out, 2);
    checkOutput("pause acc frozen", busA.acc_out, 2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("step pc %0d", i), busA.pc_out, stepPc[i]);
      checkOutput($sformatf("step acc %0d", i), busA.acc_out, stepAcc[i]);
      checkOutput($sformatf("step state %0d", i), busA.state_out, 2'b10);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume run", busA.state_out, 2'b01);
    waitHalt(10, "resume halt");
    checkOutput("resume halt pc", busA.pc_out, 3);
    checkOutput("resume halt acc", busA.acc_out, 0);

    // Stepped table through every ISA class
    resetDut();
    for (int i = 0; i < 16; i++) loadWord(vecs[i].addr, vecs[i].instr);
    busA.dbg_addr = 4'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("table pause", busA.state_out, 2'b10);
    checkOutput("table pc0", busA.pc_out, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("vec %0d acc", i), busA.acc_out, vecs[i].acc);
      checkOutput($sformatf("vec %0d pc", i), busA.pc_out, vecs[i].pc);
      checkOutput($sformatf("vec %0d st_valid", i), busA.st_valid, vecs[i].stValid);
      if (vecs[i].stValid) begin
        checkOutput($sformatf("vec %0d st_addr", i), busA.st_addr, 0);
        checkOutput($sformatf("vec %0d st_data", i), busA.st_data, 8'h01);
      end
    end
    checkOutput("table dbg dmem0", busA.dbg_data, 8'h01);

    // Rewrite the instruction at pc while paused, then step it
    loadWord(4'd13, 8'h39);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("patched step acc", busA.acc_out, 8'h03);
    checkOutput("patched step pc", busA.pc_out, 14);

    // Falling off the end: halt without wrap, wrap with wrap enabled
    resetDut();
    for (int i = 0; i < 16; i++) begin
      busA.prog_we = 1'b1; busA.prog_addr = 4'(i); busA.prog_data = 8'h07;
      busW.prog_we = 1'b1; busW.prog_addr = 4'(i); busW.prog_data = 8'h07;
      tick();
    end
    busA.prog_we = 1'b0;
    busW.prog_we = 1'b0;
    busA.start = 1'b1;
    busW.start = 1'b1;
    tick();
    busA.start = 1'b0;
    busW.start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checkOutput("nowrap pc15", busA.pc_out, 15);
    checkOutput("nowrap running", busA.state_out, 2'b01);
    tick();
    checkOutput("nowrap halt state", busA.state_out, 2'b11);
    checkOutput("nowrap halt pc", busA.pc_out, 15);
    checkOutput("wrap pc", busW.pc_out, 0);
    checkOutput("wrap state", busW.state_out, 2'b01);

    // Host writes during RUN must be ignored
    resetDut();
    loadWord(4'd0, 8'h19);
    loadWord(4'd1, 8'h07);
    loadWord(4'd2, 8'h07);
    loadWord(4'd3, 8'h0F);
    applyStimulus(1'b1, 1'b0, 1'b0);
    busA.prog_we = 1'b1; busA.prog_addr = 4'd2; busA.prog_data = 8'h79;
    tick();
    busA.prog_we = 1'b0;
    waitHalt(10, "run write halt");
    checkOutput("run write ignored", busA.acc_out, 8'h01);

    // Asynchronous reset in the middle of a running loop
    loadWord(4'd0, 8'h59);
    loadWord(4'd1, 8'h2B);
    loadWord(4'd2, 8'h0C);
    busA.dbg_addr = 4'd2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("pre reset dmem", busA.dbg_data, 8'h05);
    checkOutput("pre reset running", busA.state_out, 2'b01);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset state", busA.state_out, 2'b00);
    checkOutput("async reset pc", busA.pc_out, 0);
    checkOutput("async reset acc", busA.acc_out, 0);
    checkOutput("async reset dmem", busA.dbg_data, 0);
    tick();
    checkOutput("reset held state", busA.state_out, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("imem cleared halts", busA.state_out, 2'b11);
    checkOutput("imem cleared pc", busA.pc_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
